// File: rtl/cv32e40p_apu_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_apu_mux_pkg
// Description : Shared types for the multi-channel APU multiplexer.
//               ch_id_t is wide enough for up to 8 channels plus one
//               spare code, which marks an illegal-channel dispatch.
// Revision    : 1.0 - initial release
// ============================================================================
package cv32e40p_apu_mux_pkg;

    // Channel identifier stored in the order FIFO (fits NUM_CH up to 8).
    localparam int unsigned CH_ID_W = 4;
    typedef logic [CH_ID_W-1:0] ch_id_t;

    // Marker for a dispatch to a non-existent channel.
    localparam ch_id_t CH_ILLEGAL = '1;

    // Default upstream flag width and the matching result entry layout.
    localparam int unsigned RES_FLAGS_W = 5;
    typedef struct packed {
        logic [31:0]            result;
        logic [RES_FLAGS_W-1:0] rflags;
    } res_entry_t;

endpackage : cv32e40p_apu_mux_pkg
`default_nettype wire

// File: rtl/cv32e40p_apu_mux_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_apu_mux_fifo
// Description : Generic synchronous FIFO, first-word-fall-through read port.
//               Pushes while full and pops while empty are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_apu_mux_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign count_o = wptr - rptr;
    assign empty_o = (wptr == rptr);
    assign full_o  = (count_o == (AW+1)'(DEPTH));
    assign rdata_o = mem[rptr[AW-1:0]];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= wdata_i;
        end
    end

    // Pointer advance on push and pop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

endmodule : cv32e40p_apu_mux_fifo
`default_nettype wire

// File: rtl/cv32e40p_apu_mux.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_apu_mux
// Description : Steers core APU requests to NUM_CH units and returns their
//               results strictly in issue order. An order FIFO records the
//               channel of each granted request; per-channel result FIFOs
//               hold results that complete ahead of older requests.
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_apu_mux
    import cv32e40p_apu_mux_pkg::*;
#(
    parameter int unsigned NUM_CH          = 2,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned NARGS           = 3,
    parameter int unsigned WOP             = 6,
    parameter int unsigned NDSFLAGS        = 15,
    parameter int unsigned NUSFLAGS        = 5,
    parameter int unsigned CH_W            = $clog2(NUM_CH) + 1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               apu_req_i,
    output logic                               apu_gnt_o,
    input  logic [CH_W-1:0]                    apu_ch_i,
    input  logic [NARGS*32-1:0]                apu_operands_i,
    input  logic [WOP-1:0]                     apu_op_i,
    input  logic [NDSFLAGS-1:0]                apu_flags_i,
    output logic                               apu_rvalid_o,
    output logic [31:0]                        apu_result_o,
    output logic [NUSFLAGS-1:0]                apu_rflags_o,
    output logic [NUM_CH-1:0]                  ch_req_o,
    input  logic [NUM_CH-1:0]                  ch_gnt_i,
    output logic [NARGS*32-1:0]                ch_operands_o,
    output logic [WOP-1:0]                     ch_op_o,
    output logic [NDSFLAGS-1:0]                ch_flags_o,
    input  logic [NUM_CH-1:0]                  ch_rvalid_i,
    input  logic [NUM_CH*32-1:0]               ch_result_i,
    input  logic [NUM_CH*NUSFLAGS-1:0]         ch_rflags_i,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
    output logic                               err_o
);
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int unsigned RW = 32 + NUSFLAGS;

    logic          full;
    logic          ch_legal;
    logic          sel_gnt;
    logic          handshake;
    ch_id_t        push_id;
    ch_id_t        head;
    logic          order_empty;
    logic          order_full_unused;
    logic          head_illegal;
    logic          head_avail;
    logic [RW-1:0] head_data;
    logic          retire;

    logic [NUM_CH-1:0] res_empty;
    logic [NUM_CH-1:0] acc;
    logic [NUM_CH-1:0] unexp;
    logic [NUM_CH-1:0] head_is;
    logic [RW-1:0]     res_rdata [NUM_CH];

    // Operand, op and flag buses go to every unit unchanged.
    assign ch_operands_o = apu_operands_i;
    assign ch_op_o       = apu_op_i;
    assign ch_flags_o    = apu_flags_i;

    // A retire in the same cycle does not open a slot for dispatch.
    assign full     = (outstanding_o == OW'(MAX_OUTSTANDING));
    assign ch_legal = (apu_ch_i < CH_W'(NUM_CH));

    // Route the request to the selected unit and pick up its grant.
    always_comb begin
        ch_req_o = '0;
        sel_gnt  = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_legal && (apu_ch_i == CH_W'(c))) begin
                ch_req_o[c] = apu_req_i && !full;
                sel_gnt     = ch_gnt_i[c];
            end
        end
    end

    // Illegal channels are accepted immediately and retired as errors.
    assign apu_gnt_o = apu_req_i && !full && (ch_legal ? sel_gnt : 1'b1);
    assign handshake = apu_gnt_o;
    assign push_id   = ch_legal ? ch_id_t'(apu_ch_i) : CH_ILLEGAL;

    cv32e40p_apu_mux_fifo #(
        .WIDTH (CH_ID_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_order_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (handshake),
        .wdata_i (push_id),
        .pop_i   (retire),
        .rdata_o (head),
        .full_o  (order_full_unused),
        .empty_o (order_empty),
        .count_o (outstanding_o)
    );

    assign head_illegal = (head >= ch_id_t'(NUM_CH));

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [OW-1:0] pending;
        logic          issue_here;
        logic          bypass;
        logic          push_res;
        logic          pop_res;
        logic          full_unused;
        logic [OW-1:0] count_unused;

        assign issue_here = handshake && ch_legal && (apu_ch_i == CH_W'(c));
        assign acc[c]     = ch_rvalid_i[c] && (pending != '0);
        assign unexp[c]   = ch_rvalid_i[c] && (pending == '0);
        assign head_is[c] = !order_empty && (head == ch_id_t'(c));
        // A result for an empty FIFO at the head retires straight through.
        assign bypass     = head_is[c] && res_empty[c] && acc[c];
        assign push_res   = acc[c] && !bypass;
        assign pop_res    = head_is[c] && !res_empty[c];

        // Requests granted to this unit that still await a result.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                pending <= '0;
            end else begin
                pending <= pending + OW'(issue_here) - OW'(acc[c]);
            end
        end

        cv32e40p_apu_mux_fifo #(
            .WIDTH (RW),
            .DEPTH (MAX_OUTSTANDING)
        ) u_res_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (push_res),
            .wdata_i ({ch_result_i[c*32 +: 32], ch_rflags_i[c*NUSFLAGS +: NUSFLAGS]}),
            .pop_i   (pop_res),
            .rdata_o (res_rdata[c]),
            .full_o  (full_unused),
            .empty_o (res_empty[c]),
            .count_o (count_unused)
        );
    end

    // Select the head channel's data, from its FIFO or the live bus.
    always_comb begin
        head_avail = 1'b0;
        head_data  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (head_is[c]) begin
                head_avail = !res_empty[c] || acc[c];
                head_data  = res_empty[c]
                           ? {ch_result_i[c*32 +: 32], ch_rflags_i[c*NUSFLAGS +: NUSFLAGS]}
                           : res_rdata[c];
            end
        end
    end

    assign retire = !order_empty && (head_illegal || head_avail);

    // Register retired results; error flag is sticky until reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            apu_rvalid_o <= 1'b0;
            apu_result_o <= '0;
            apu_rflags_o <= '0;
            err_o        <= 1'b0;
        end else begin
            apu_rvalid_o <= retire;
            if (retire) begin
                if (head_illegal) begin
                    apu_result_o <= '0;
                    apu_rflags_o <= '1;
                end else begin
                    {apu_result_o, apu_rflags_o} <= head_data;
                end
            end
            err_o <= err_o | (retire && head_illegal) | (|unexp);
        end
    end

endmodule : cv32e40p_apu_mux
`default_nettype wire

// File: tb/tb_cv32e40p_apu_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_cv32e40p_apu_mux
// Description : Self-checking bench: directed scenarios plus randomized
//               traffic against a transaction-level in-order model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cv32e40p_apu_mux;
    localparam int NUM_CH  = 2;
    localparam int MAX_OUT = 4;
    localparam int NARGS   = 3;
    localparam int WOP     = 6;
    localparam int NDS     = 15;
    localparam int NUS     = 5;
    localparam int CH_W    = 2;
    localparam int OW      = 3;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      apu_req;
    logic                      apu_gnt;
    logic [CH_W-1:0]           apu_ch;
    logic [NARGS*32-1:0]       apu_operands;
    logic [WOP-1:0]            apu_op;
    logic [NDS-1:0]            apu_flags;
    logic                      apu_rvalid;
    logic [31:0]               apu_result;
    logic [NUS-1:0]            apu_rflags;
    logic [NUM_CH-1:0]         ch_req;
    logic [NUM_CH-1:0]         ch_gnt;
    logic [NARGS*32-1:0]       ch_operands;
    logic [WOP-1:0]            ch_op;
    logic [NDS-1:0]            ch_flags;
    logic [NUM_CH-1:0]         ch_rvalid;
    logic [NUM_CH*32-1:0]      ch_result;
    logic [NUM_CH*NUS-1:0]     ch_rflags;
    logic [OW-1:0]             outstanding;
    logic                      err;

    cv32e40p_apu_mux dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .apu_req_i      (apu_req),
        .apu_gnt_o      (apu_gnt),
        .apu_ch_i       (apu_ch),
        .apu_operands_i (apu_operands),
        .apu_op_i       (apu_op),
        .apu_flags_i    (apu_flags),
        .apu_rvalid_o   (apu_rvalid),
        .apu_result_o   (apu_result),
        .apu_rflags_o   (apu_rflags),
        .ch_req_o       (ch_req),
        .ch_gnt_i       (ch_gnt),
        .ch_operands_o  (ch_operands),
        .ch_op_o        (ch_op),
        .ch_flags_o     (ch_flags),
        .ch_rvalid_i    (ch_rvalid),
        .ch_result_i    (ch_result),
        .ch_rflags_i    (ch_rflags),
        .outstanding_o  (outstanding),
        .err_o          (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Transaction-level model: one record per accepted request, in issue order.
    typedef struct {
        bit              illegal;
        int              ch;
        logic [31:0]     res;
        logic [NUS-1:0]  fl;
        int              issue;
        int              ready;   // cycle the result became known, -1 if not yet
    } txn_t;

    txn_t           txq[$];
    int             cyc = 0;
    bit             m_err;
    bit             m_rv;
    logic [31:0]    m_res;
    logic [NUS-1:0] m_fl;

    task automatic model_clear();
        txq.delete();
        m_err = 0;
        m_rv  = 0;
        m_res = '0;
        m_fl  = '0;
    endtask

    // One clock cycle with the currently driven inputs.
    task automatic step();
        bit                full;
        bit                legal;
        bit                e_gnt;
        logic [NUM_CH-1:0] e_req;
        int                idx;
        txn_t              t;
        full  = (txq.size() == MAX_OUT);
        legal = (int'(apu_ch) < NUM_CH);
        e_req = '0;
        if (apu_req && !full && legal) e_req[apu_ch] = 1'b1;
        e_gnt = apu_req && !full && (legal ? ch_gnt[apu_ch] : 1'b1);
        #1;
        check_eq("ch_req", ch_req, e_req);
        check_eq("apu_gnt", apu_gnt, e_gnt);
        check_eq("passthru", {ch_operands, ch_op, ch_flags}, {apu_operands, apu_op, apu_flags});
        // Each unit answers its oldest unanswered request; others are errors.
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_rvalid[c]) begin
                idx = -1;
                for (int i = 0; i < txq.size(); i++)
                    if (idx < 0 && !txq[i].illegal && txq[i].ch == c && txq[i].ready < 0) idx = i;
                if (idx < 0) m_err = 1;
                else begin
                    txq[idx].res   = ch_result[c*32 +: 32];
                    txq[idx].fl    = ch_rflags[c*NUS +: NUS];
                    txq[idx].ready = cyc;
                end
            end
        end
        m_rv = 0;
        if (txq.size() > 0 && txq[0].ready >= 0 && txq[0].ready <= cyc) begin
            m_rv  = 1;
            m_res = txq[0].res;
            m_fl  = txq[0].fl;
            if (txq[0].illegal) m_err = 1;
            void'(txq.pop_front());
        end
        if (e_gnt) begin
            t.illegal = !legal;
            t.ch      = int'(apu_ch);
            t.res     = '0;
            t.fl      = legal ? '0 : '1;
            t.issue   = cyc;
            t.ready   = legal ? -1 : cyc + 1;
            txq.push_back(t);
        end
        @(posedge clk);
        #1;
        cyc++;
        check_eq("rvalid", apu_rvalid, m_rv);
        check_eq("result", apu_result, m_res);
        check_eq("rflags", apu_rflags, m_fl);
        check_eq("outstanding", outstanding, txq.size());
        check_eq("err", err, m_err);
    endtask

    task automatic cyc_in(input bit req, input int ch, input logic [NUM_CH-1:0] gnt,
                          input logic [NUM_CH-1:0] rv, input logic [31:0] r0, input logic [31:0] r1);
        apu_req      = req;
        apu_ch       = CH_W'(ch);
        ch_gnt       = gnt;
        ch_rvalid    = rv;
        ch_result    = {r1, r0};
        ch_rflags    = NUM_CH*NUS'($urandom);
        apu_operands = {$urandom, $urandom, $urandom};
        apu_op       = WOP'($urandom);
        apu_flags    = NDS'($urandom);
        step();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        apu_req   = 1'b0;
        ch_gnt    = '0;
        ch_rvalid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        check_eq("rst_rvalid", apu_rvalid, 1'b0);
        check_eq("rst_result", apu_result, 32'h0);
        check_eq("rst_rflags", apu_rflags, 5'h0);
        check_eq("rst_outstanding", outstanding, 3'd0);
        check_eq("rst_err", err, 1'b0);
        check_eq("rst_gnt", apu_gnt, 1'b0);
        check_eq("rst_ch_req", ch_req, 2'b00);
    endtask

    initial begin
        rst = 1'b1; apu_req = 0; apu_ch = '0; ch_gnt = '0; ch_rvalid = '0;
        ch_result = '0; ch_rflags = '0; apu_operands = '0; apu_op = '0; apu_flags = '0;
        model_clear();
        #1;
        do_reset();

        // Single op on channel 0 with 3-cycle unit latency.
        cyc_in(1, 0, 2'b01, 2'b00, 0, 0);
        check_eq("single_out1", outstanding, 3'd1);
        cyc_in(0, 0, 2'b00, 2'b00, 0, 0);
        cyc_in(0, 0, 2'b00, 2'b00, 0, 0);
        cyc_in(0, 0, 2'b00, 2'b01, 32'h3F800000, 0);
        check_eq("single_res", apu_result, 32'h3F800000);
        check_eq("single_out0", outstanding, 3'd0);
        cyc_in(0, 0, 2'b00, 2'b00, 0, 0);

        // Out-of-order completion is reordered.
        do_reset();
        cyc_in(1, 0, 2'b01, 2'b00, 0, 0);
        cyc_in(1, 1, 2'b10, 2'b00, 0, 0);
        cyc_in(0, 0, 2'b00, 2'b10, 0, 32'hBBBB);
        check_eq("ooo_wait", apu_rvalid, 1'b0);
        cyc_in(0, 0, 2'b00, 2'b00, 0, 0);
        cyc_in(0, 0, 2'b00, 2'b00, 0, 0);
        cyc_in(0, 0, 2'b00, 2'b01, 32'hAAAA, 0);
        check_eq("ooo_first", apu_result, 32'hAAAA);
        cyc_in(0, 0, 2'b00, 2'b00, 0, 0);
        check_eq("ooo_second", apu_result, 32'hBBBB);

        // Full: a retire does not free a slot in its own cycle.
        do_reset();
        repeat (4) cyc_in(1, 0, 2'b01, 2'b00, 0, 0);
        check_eq("full_count", outstanding, 3'd4);
        cyc_in(1, 0, 2'b01, 2'b00, 0, 0);
        cyc_in(1, 0, 2'b01, 2'b01, 32'h1111, 0);
        check_eq("full_after_retire", outstanding, 3'd3);
        cyc_in(1, 0, 2'b01, 2'b00, 0, 0);
        check_eq("full_regrant", outstanding, 3'd4);
        repeat (4) cyc_in(0, 0, 2'b00, 2'b01, $urandom, 0);

        // Illegal channel: immediate grant, error result.
        do_reset();
        cyc_in(1, 2, 2'b11, 2'b00, 0, 0);
        cyc_in(0, 0, 2'b00, 2'b00, 0, 0);
        check_eq("illegal_rvalid", apu_rvalid, 1'b1);
        check_eq("illegal_rflags", apu_rflags, 5'h1F);
        check_eq("illegal_err", err, 1'b1);

        // Unexpected result with nothing outstanding.
        do_reset();
        cyc_in(0, 0, 2'b00, 2'b10, 0, 32'hDEAD);
        check_eq("unexp_err", err, 1'b1);

        // Reset mid-flight, then a stale result arrives.
        do_reset();
        repeat (3) cyc_in(1, 1, 2'b10, 2'b00, 0, 0);
        do_reset();
        cyc_in(0, 0, 2'b00, 2'b10, 0, 32'h5555);
        check_eq("late_err", err, 1'b1);

        // Randomized traffic with emulated units of random latency.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [NUM_CH-1:0] rv;
            logic [31:0]       r [NUM_CH];
            int                ch;
            rv = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                int idx;
                r[c] = $urandom;
                idx  = -1;
                for (int i = 0; i < txq.size(); i++)
                    if (idx < 0 && !txq[i].illegal && txq[i].ch == c && txq[i].ready < 0) idx = i;
                if (idx >= 0 && txq[idx].issue < cyc && $urandom_range(0, 2) == 0) rv[c] = 1'b1;
            end
            ch = ($urandom_range(0, 9) == 0) ? $urandom_range(2, 3) : $urandom_range(0, 1);
            cyc_in($urandom_range(0, 9) < 6, ch, NUM_CH'($urandom), rv, r[0], r[1]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_cv32e40p_apu_mux
`default_nettype wire
